// File: rtl/maze_switch_allocator_if.sv
// rtl/maze_switch_allocator_if.sv - Request/grant bundle between route units, allocator and crossbar registers.
interface maze_switch_allocator_if #(
    parameter int DROP_CNT_W = 8
);
    logic [4:0]            in_valid;
    logic [24:0]           in_route_req;
    logic [4:0]            out_ready;
    logic [24:0]           out_gnt;
    logic [4:0]            in_pop;
    logic [4:0]            out_valid;
    logic [14:0]           out_src;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output in_valid, in_route_req, out_ready,
        input  out_gnt, in_pop, out_valid, out_src, drop_cnt
    );

    modport slave (
        input  in_valid, in_route_req, out_ready,
        output out_gnt, in_pop, out_valid, out_src, drop_cnt
    );
endinterface

// File: rtl/maze_switch_allocator.sv
// rtl/maze_switch_allocator.sv - Five-output round-robin switch allocator with partial multicast service.
module maze_switch_allocator #(
    parameter logic [2:0] RR_INIT    = 3'd0,
    parameter int         DROP_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    maze_switch_allocator_if.slave bus
);
    localparam int SUM_W = DROP_CNT_W + 3;
    localparam logic [DROP_CNT_W-1:0] CNT_MAX = {DROP_CNT_W{1'b1}};

    logic [4:0] done [5];
    logic [2:0] ptr  [5];

    logic [4:0] route  [5];
    logic [4:0] req    [5];
    logic [4:0] gnt_o  [5];
    logic [2:0] win    [5];
    logic [4:0] g_in   [5];
    logic [4:0] done_n [5];
    logic [4:0] pop;
    logic [4:0] drop;
    logic [2:0] n_drop;
    logic [SUM_W-1:0] cnt_sum;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            route[i] = bus.in_route_req[5*i +: 5];
            req[i]   = bus.in_valid[i] ? (route[i] & ~done[i]) : 5'b0;
        end
    end

    // Per-output scan starting at the pointer; the first hit wins.
    always_comb begin
        logic [3:0] idx;
        idx = '0;
        for (int o = 0; o < 5; o++) begin
            gnt_o[o] = '0;
            win[o]   = '0;
            if (bus.out_ready[o]) begin
                for (int k = 0; k < 5; k++) begin
                    idx = ({1'b0, ptr[o]} + 4'(k)) % 4'd5;
                    if (gnt_o[o] == 5'b0 && req[idx[2:0]][o]) begin
                        gnt_o[o][idx[2:0]] = 1'b1;
                        win[o]             = idx[2:0];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            for (int o = 0; o < 5; o++) begin
                g_in[i][o]            = gnt_o[o][i];
                bus.out_gnt[5*o + i]  = gnt_o[o][i];
            end
        end
    end

    // A head pops when dropped (empty request) or when its last requested output is taken.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < 5; i++) begin
            drop[i] = bus.in_valid[i] && (route[i] == 5'b0);
            pop[i]  = bus.in_valid[i] &&
                      ((route[i] == 5'b0) || ((done[i] | g_in[i]) == route[i]));
            if (pop[i] && route[i] != 5'b0)
                done_n[i] = 5'b0;
            else
                done_n[i] = done[i] | g_in[i];
            n_drop = n_drop + 3'(drop[i]);
        end
        cnt_sum = SUM_W'(bus.drop_cnt) + SUM_W'(n_drop);
    end

    assign bus.in_pop = pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                done[i] <= '0;
                ptr[i]  <= RR_INIT;
            end
            bus.out_valid <= '0;
            bus.out_src   <= '0;
            bus.drop_cnt  <= '0;
        end else begin
            for (int i = 0; i < 5; i++)
                done[i] <= done_n[i];
            for (int o = 0; o < 5; o++) begin
                bus.out_valid[o] <= |gnt_o[o];
                if (|gnt_o[o]) begin
                    ptr[o]              <= (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
                    bus.out_src[3*o +: 3] <= win[o];
                end
            end
            if (cnt_sum > SUM_W'(CNT_MAX))
                bus.drop_cnt <= CNT_MAX;
            else
                bus.drop_cnt <= cnt_sum[DROP_CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_maze_switch_allocator.sv
// tb/tb_maze_switch_allocator.sv - Directed self-checking bench for maze_switch_allocator.
module tb_maze_switch_allocator;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    maze_switch_allocator_if #(.DROP_CNT_W(8)) bus ();

    maze_switch_allocator #(.RR_INIT(3'd0), .DROP_CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] r);
        bus.in_route_req[5*i +: 5] = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_win [4];

    initial begin
        vectors      = 0;
        miscompares  = 0;
        exp_win      = '{0, 2, 0, 2};
        rst_n        = 1'b0;
        bus.in_valid = '0;
        bus.in_route_req = '0;
        bus.out_ready = '0;
        #12;
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_out_src",   32'(bus.out_src),   32'h0);
        chk("reset_drop_cnt",  32'(bus.drop_cnt),  32'h0);
        chk("reset_out_gnt",   32'(bus.out_gnt),   32'h0);
        rst_n = 1'b1;
        tick();

        // Unicast W -> E
        bus.in_valid = 5'b00010;
        set_req(1, 5'b01000);
        bus.out_ready = 5'h1F;
        #1;
        chk("uni_gnt", 32'(bus.out_gnt), 32'(25'd1 << 16));
        chk("uni_pop", 32'(bus.in_pop),  32'h02);
        tick();
        chk("uni_out_valid", 32'(bus.out_valid), 32'h08);
        chk("uni_out_src",   32'(bus.out_src),   32'h0200);

        // N and S contend for B
        bus.in_route_req = '0;
        bus.in_valid = 5'b00101;
        set_req(0, 5'b10000);
        set_req(2, 5'b10000);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("cont_gnt_%0d", c), 32'(bus.out_gnt), 32'(25'd1 << (20 + exp_win[c])));
            chk($sformatf("cont_pop_%0d", c), 32'(bus.in_pop),  32'(5'd1 << exp_win[c]));
            tick();
        end
        chk("cont_out_src_b", 32'(bus.out_src[14:12]), 32'd2);

        // Multicast E -> N,W,B served over two cycles
        bus.in_route_req = '0;
        bus.in_valid = 5'b01000;
        set_req(3, 5'b10011);
        bus.out_ready = 5'b10001;
        #1;
        chk("mc0_gnt", 32'(bus.out_gnt), 32'((25'd1 << 3) | (25'd1 << 23)));
        chk("mc0_pop", 32'(bus.in_pop),  32'h00);
        tick();
        bus.out_ready = 5'b10011;
        #1;
        chk("mc1_gnt", 32'(bus.out_gnt), 32'(25'd1 << 8));
        chk("mc1_pop", 32'(bus.in_pop),  32'h08);
        tick();
        chk("mc1_out_valid", 32'(bus.out_valid), 32'h02);
        chk("mc1_out_src_w", 32'(bus.out_src[5:3]), 32'd3);

        // Broadcast from local
        bus.in_route_req = '0;
        bus.in_valid = 5'b10000;
        set_req(4, 5'b11111);
        bus.out_ready = 5'h1F;
        #1;
        chk("bc_gnt", 32'(bus.out_gnt), 32'h1084210);
        chk("bc_pop", 32'(bus.in_pop),  32'h10);
        tick();
        chk("bc_out_valid", 32'(bus.out_valid), 32'h1F);
        chk("bc_out_src",   32'(bus.out_src),   32'h4924);

        // Drops and saturation
        bus.in_route_req = '0;
        bus.in_valid = 5'b00011;
        #1;
        chk("drop_gnt", 32'(bus.out_gnt), 32'h0);
        chk("drop_pop", 32'(bus.in_pop),  32'h03);
        tick();
        chk("drop_cnt_2", 32'(bus.drop_cnt), 32'd2);
        bus.in_valid = 5'h1F;
        repeat (50) @(posedge clk);
        #1;
        chk("drop_cnt_252", 32'(bus.drop_cnt), 32'd252);
        bus.in_valid = 5'b00011;
        tick();
        chk("drop_cnt_254", 32'(bus.drop_cnt), 32'd254);
        tick();
        chk("drop_cnt_sat", 32'(bus.drop_cnt), 32'd255);
        bus.in_valid = 5'h1F;
        tick();
        chk("drop_cnt_hold", 32'(bus.drop_cnt), 32'd255);

        // Reset in the middle of a multicast
        bus.in_route_req = '0;
        bus.in_valid = 5'b00001;
        set_req(0, 5'b00101);
        bus.out_ready = 5'b00001;
        #1;
        chk("rst_mc_gnt", 32'(bus.out_gnt), 32'h1);
        chk("rst_mc_pop", 32'(bus.in_pop),  32'h0);
        tick();
        bus.in_valid = 5'b10001;
        set_req(4, 5'b00001);
        bus.out_ready = 5'h1F;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_drop_cnt",  32'(bus.drop_cnt),  32'h0);
        chk("rst_gnt",       32'(bus.out_gnt),   32'h401);
        chk("rst_pop",       32'(bus.in_pop),    32'h01);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rel_gnt", 32'(bus.out_gnt), 32'h401);
        tick();
        chk("rel_out_valid", 32'(bus.out_valid), 32'h05);
        chk("rel_out_src",   32'(bus.out_src),   32'h0);
        bus.in_valid = 5'b10000;
        #1;
        chk("rel_next_gnt", 32'(bus.out_gnt), 32'h10);
        chk("rel_next_pop", 32'(bus.in_pop),  32'h10);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
